// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory read/write data port.
// Defining ARB_RD_TIMEOUT_EN adds a read timeout that completes with 16'hDEAD and req_err.
module mem_port_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0,
  parameter int RD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_rd_en   [2],
  input  logic [1:0]        req_wr_en   [2],
  input  logic [ADDR_W-1:0] req_addr    [2],
  input  logic [DATA_W-1:0] req_wr_data [2],
  output logic              req_grant   [2],
  output logic              req_done    [2],
  output logic [DATA_W-1:0] req_rd_data [2],
  output logic              req_err     [2],
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_done,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [1:0]        mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t            state, state_nx;
  logic              owner, owner_nx;
  logic              last, last_nx;
  logic              err, err_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [DATA_W-1:0] wdata, wdata_nx;
  logic [DATA_W-1:0] rdata, rdata_nx;
  logic [1:0]        wen, wen_nx;
  logic              pend [2];
  logic              win;
  logic              tmo_hit;

  logic              rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [1:0]        wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              grant_d   [2];
  logic              done_d    [2];
  logic [DATA_W-1:0] rd_data_d [2];
  logic              err_d     [2];

  assign pend[0] = req_rd_en[0] | (|req_wr_en[0]);
  assign pend[1] = req_rd_en[1] | (|req_wr_en[1]);

`ifdef ARB_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Held at zero outside READ, so it starts from zero on every READ entry.
  always_ff @(posedge clk) begin
    if (!reset || state != READ) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(RD_TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register: control and all outputs are reset; latched request data is not.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      err         <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 2'b00;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      for (int r = 0; r < 2; r++) begin
        req_grant[r]   <= 1'b0;
        req_done[r]    <= 1'b0;
        req_rd_data[r] <= '0;
        req_err[r]     <= 1'b0;
      end
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      last        <= last_nx;
      err         <= err_nx;
      mem_rd_en   <= rd_en_d;
      mem_rd_addr <= rd_addr_d;
      mem_wr_en   <= wr_en_d;
      mem_wr_addr <= wr_addr_d;
      mem_wr_data <= wr_data_d;
      for (int r = 0; r < 2; r++) begin
        req_grant[r]   <= grant_d[r];
        req_done[r]    <= done_d[r];
        req_rd_data[r] <= rd_data_d[r];
        req_err[r]     <= err_d[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    addr  <= addr_nx;
    wdata <= wdata_nx;
    wen   <= wen_nx;
    rdata <= rdata_nx;
  end

  // Next state: arbitration and request latching happen only in IDLE.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    err_nx   = err;
    addr_nx  = addr;
    wdata_nx = wdata;
    wen_nx   = wen;
    rdata_nx = rdata;
    win      = 1'b0;
    case (state)
      IDLE: begin
        if (pend[0] | pend[1]) begin
          if (pend[0] & pend[1]) win = (FIXED_PRIO != 0) ? 1'b0 : ~last;
          else                   win = pend[1];
          owner_nx = win;
          last_nx  = win;
          err_nx   = 1'b0;
          addr_nx  = req_addr[win];
          wdata_nx = req_wr_data[win];
          wen_nx   = req_wr_en[win];
          state_nx = (req_wr_en[win] != 2'b00) ? WRITE : READ;
        end
      end
      WRITE: state_nx = IDLE;
      READ: begin
        if (mem_rd_done) begin
          rdata_nx = mem_rd_data;
          err_nx   = 1'b0;
          state_nx = RESP;
        end else if (tmo_hit) begin
          rdata_nx = DATA_W'(16'hDEAD);
          err_nx   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered with the state.
  always_comb begin
    rd_en_d   = (state_nx == READ);
    rd_addr_d = (state_nx == READ)  ? addr_nx  : '0;
    wr_en_d   = (state_nx == WRITE) ? wen_nx   : 2'b00;
    wr_addr_d = (state_nx == WRITE) ? addr_nx  : '0;
    wr_data_d = (state_nx == WRITE) ? wdata_nx : '0;
    for (int r = 0; r < 2; r++) begin
      grant_d[r]   = (state_nx != IDLE) && (owner_nx == 1'(r));
      done_d[r]    = ((state_nx == WRITE) || (state_nx == RESP)) && (owner_nx == 1'(r));
      err_d[r]     = (state_nx == RESP) && (owner_nx == 1'(r)) && err_nx;
      rd_data_d[r] = ((state_nx == RESP) && (owner_nx == 1'(r))) ? rdata_nx : req_rd_data[r];
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps plus random rounds against a transaction-level model.
// Also covers the ARB_RD_TIMEOUT_EN build when that macro is defined.
module tb_mem_port_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;
`ifdef ARB_RD_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic          req_rd_en [2];
  logic [1:0]    req_wr_en [2];
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_wr_data [2];
  logic          req_grant [2], req_done [2], req_err [2];
  logic [DW-1:0] req_rd_data [2];
  logic          mem_rd_en, mem_rd_done;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data, mem_wr_data;
  logic [1:0]    mem_wr_en;

  logic          fp_rd_en [2];
  logic [1:0]    fp_wr_en [2];
  logic [AW-1:0] fp_addr [2];
  logic [DW-1:0] fp_wr_data [2];
  logic          fp_grant [2], fp_done [2], fp_err [2];
  logic [DW-1:0] fp_rd_data [2];
  logic          fp_mem_rd_en, fp_mem_rd_done;
  logic [AW-1:0] fp_mem_rd_addr, fp_mem_wr_addr;
  logic [DW-1:0] fp_mem_rd_data, fp_mem_wr_data;
  logic [1:0]    fp_mem_wr_en;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .RD_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .req_grant(req_grant),
    .req_done(req_done), .req_rd_data(req_rd_data), .req_err(req_err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_done(mem_rd_done),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data));

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .RD_TIMEOUT(4)) dut_fp (
    .clk(clk), .reset(reset), .req_rd_en(fp_rd_en), .req_wr_en(fp_wr_en),
    .req_addr(fp_addr), .req_wr_data(fp_wr_data), .req_grant(fp_grant),
    .req_done(fp_done), .req_rd_data(fp_rd_data), .req_err(fp_err),
    .mem_rd_en(fp_mem_rd_en), .mem_rd_addr(fp_mem_rd_addr), .mem_rd_done(fp_mem_rd_done),
    .mem_rd_data(fp_mem_rd_data), .mem_wr_en(fp_mem_wr_en), .mem_wr_addr(fp_mem_wr_addr),
    .mem_wr_data(fp_mem_wr_data));

  typedef struct {
    int            r;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    wen;
    bit            tmo;
  } op_t;

  int n_asrt = 0, n_fail = 0, cyc = 0;
  logic [DW-1:0] mem [32768];
  logic [DW-1:0] ref_mem [32768];
  op_t exp_q[$];
  bit  last_ptr = 1'b1;
  bit  stall = 1'b0, junk_en = 1'b0, prev_gnt_any = 1'b0, prev_done_drv = 1'b0;
  int  mem_lat = 1, rd_cnt = 0;
  int  apply_cyc = 0, first_rd_cyc = -1, done_cyc = -1, wr_cycles = 0;
  logic [AW-1:0] first_rd_addr;
  int  fp_cnt [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction

  task automatic clear_inputs();
    for (int r = 0; r < 2; r++) begin
      req_rd_en[r] = 1'b0; req_wr_en[r] = 2'b00; req_addr[r] = '0; req_wr_data[r] = '0;
      fp_rd_en[r] = 1'b0; fp_wr_en[r] = 2'b00; fp_addr[r] = '0; fp_wr_data[r] = '0;
    end
  endtask

  // One clock: scoreboard the observed cycle, then play memory for the next edge.
  task automatic tick();
    op_t e;
    logic [DW-1:0] expd;
    @(negedge clk);
    cyc++;
    chk("rd_wr_excl", 32'(mem_rd_en && (mem_wr_en != 2'b00)), 0);
    chk("one_grant", 32'(req_grant[0] && req_grant[1]), 0);
    if (mem_wr_en != 2'b00) wr_cycles++;
    if (mem_rd_en && first_rd_cyc < 0) begin first_rd_cyc = cyc; first_rd_addr = mem_rd_addr; end
    for (int r = 0; r < 2; r++) begin
      if (req_done[r]) begin
        done_cyc = cyc;
        chk("done_grant", 32'(req_grant[r]), 1);
        if (exp_q.size() == 0) chk("unexpected_done", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("done_owner", r, e.r);
          if (e.wr) begin
            chk("wr_en", 32'(mem_wr_en), 32'(e.wen));
            chk("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
            chk("wr_data", 32'(mem_wr_data), 32'(e.wdata));
            chk("wr_after_idle", 32'(prev_gnt_any), 0);
            ref_mem[e.addr] = merge(ref_mem[e.addr], e.wdata, e.wen);
            req_wr_en[r] = 2'b00;
          end else begin
            expd = e.tmo ? 16'hDEAD : ref_mem[e.addr];
            chk("rd_data", 32'(req_rd_data[r]), 32'(expd));
            if (!e.tmo) chk("rd_latency", 32'(prev_done_drv), 1);
            req_rd_en[r] = 1'b0;
          end
          chk("err", 32'(req_err[r]), 32'(e.tmo));
        end
      end
      if (fp_done[r]) begin
        fp_cnt[r]++;
        chk("fp_rd_data", 32'(fp_rd_data[r]), 32'({1'b0, fp_addr[r]}));
      end
    end
    if (mem_wr_en[0]) mem[mem_wr_addr][7:0]  = mem_wr_data[7:0];
    if (mem_wr_en[1]) mem[mem_wr_addr][15:8] = mem_wr_data[15:8];
    prev_done_drv = 1'b0;
    if (mem_rd_en) begin
      rd_cnt++;
      if (!stall && rd_cnt >= mem_lat) begin
        mem_rd_done = 1'b1; mem_rd_data = mem[mem_rd_addr]; prev_done_drv = 1'b1; rd_cnt = 0;
      end else begin
        mem_rd_done = 1'b0; mem_rd_data = 16'($urandom);
      end
    end else begin
      rd_cnt = 0;
      mem_rd_done = junk_en && ($urandom_range(0, 3) == 0);
      mem_rd_data = 16'($urandom);
    end
    prev_gnt_any = req_grant[0] | req_grant[1];
    fp_mem_rd_done = fp_mem_rd_en;
    fp_mem_rd_data = {1'b0, fp_mem_rd_addr};
  endtask

  task automatic check_zero();
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_wr_addr", 32'(mem_wr_addr), 0);
    chk("rst_wr_data", 32'(mem_wr_data), 0);
    for (int r = 0; r < 2; r++) begin
      chk("rst_grant", 32'(req_grant[r]), 0);
      chk("rst_done", 32'(req_done[r]), 0);
      chk("rst_rd_data", 32'(req_rd_data[r]), 0);
      chk("rst_err", 32'(req_err[r]), 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    check_zero();
    tick();
    reset = 1'b1;
    exp_q.delete();
    last_ptr = 1'b1;
  endtask

  // Model: requests are held until done, write before read, tie goes to the one not granted last.
  task automatic run_round(input bit rd0, input logic [1:0] wen0, input logic [AW-1:0] a0,
                           input logic [DW-1:0] d0, input bit rd1, input logic [1:0] wen1,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                           input int lat, input bit stl);
    op_t q0[$], q1[$];
    bit  win;
    if (wen0 != 2'b00) q0.push_back('{r:0, wr:1'b1, addr:a0, wdata:d0, wen:wen0, tmo:1'b0});
    if (rd0)           q0.push_back('{r:0, wr:1'b0, addr:a0, wdata:d0, wen:2'b00, tmo:stl && TMO});
    if (wen1 != 2'b00) q1.push_back('{r:1, wr:1'b1, addr:a1, wdata:d1, wen:wen1, tmo:1'b0});
    if (rd1)           q1.push_back('{r:1, wr:1'b0, addr:a1, wdata:d1, wen:2'b00, tmo:stl && TMO});
    while (q0.size() > 0 || q1.size() > 0) begin
      if (q0.size() > 0 && q1.size() > 0) win = !last_ptr;
      else                                 win = (q0.size() == 0);
      last_ptr = win;
      if (win) exp_q.push_back(q1.pop_front());
      else     exp_q.push_back(q0.pop_front());
    end
    mem_lat = lat; stall = stl; first_rd_cyc = -1; wr_cycles = 0; done_cyc = -1; apply_cyc = cyc;
    req_rd_en[0] = rd0; req_wr_en[0] = wen0; req_addr[0] = a0; req_wr_data[0] = d0;
    req_rd_en[1] = rd1; req_wr_en[1] = wen1; req_addr[1] = a1; req_wr_data[1] = d1;
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) begin
      tick();
      if (stall && !TMO && k == 20) begin
        chk("stall_rd_en", 32'(mem_rd_en), 1);
        chk("stall_no_done", exp_q.size(), 1);
        chk("stall_no_err", 32'(req_err[0]), 0);
        stall = 1'b0;
      end
    end
    stall = 1'b0;
    chk("round_complete", exp_q.size(), 0);
    if (exp_q.size() > 0) do_reset();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    mem_rd_done = 1'b0; mem_rd_data = '0; fp_mem_rd_done = 1'b0; fp_mem_rd_data = '0;
    fp_cnt[0] = 0; fp_cnt[1] = 0;
    clear_inputs();
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'(i) ^ 16'hA5A5;
      ref_mem[i] = 16'(i) ^ 16'hA5A5;
    end
    mem[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;

    // Reset, then a single read with two-cycle memory latency
    do_reset();
    run_round(1'b1, 2'b00, 15'h0010, 16'h0, 1'b0, 2'b00, 15'h0, 16'h0, 2, 1'b0);
    chk("rd_first_cycle", first_rd_cyc, apply_cyc + 1);
    chk("rd_addr_out", 32'(first_rd_addr), 32'h0010);
    chk("rd_done_cycle", done_cyc, apply_cyc + 3);

    // Tie after reset: requester 0 first, then 1; a repeated tie goes to 0 again
    do_reset();
    run_round(1'b1, 2'b00, 15'h0001, 16'h0, 1'b1, 2'b00, 15'h0002, 16'h0, 1, 1'b0);
    run_round(1'b1, 2'b00, 15'h0001, 16'h0, 1'b1, 2'b00, 15'h0002, 16'h0, 3, 1'b0);

    // Single-cycle byte write at the top address
    run_round(1'b0, 2'b00, 15'h0, 16'h0, 1'b0, 2'b01, 15'h7FFF, 16'h1234, 1, 1'b0);
    chk("wr_one_cycle", wr_cycles, 1);
    chk("wr_done_cycle", done_cyc, apply_cyc + 1);
    chk("wr_no_read", first_rd_cyc, -1);

    // Read and write from one requester against a write from the other
    run_round(1'b1, 2'b11, 15'h0040, 16'hC0DE, 1'b1, 2'b10, 15'h0040, 16'h5500, 2, 1'b0);

    // Random rounds, with stray mem_rd_done pulses outside READ
    junk_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int k0, k1;
      logic [AW-1:0] a0, a1;
      k0 = $urandom_range(0, 3); k1 = $urandom_range(0, 3);
      if (k0 == 0 && k1 == 0) k0 = 1;
      a0 = ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 15'($urandom);
      run_round(k0[0], (k0 >= 2) ? 2'($urandom_range(1, 3)) : 2'b00, a0, 16'($urandom),
                k1[0], (k1 >= 2) ? 2'($urandom_range(1, 3)) : 2'b00, a1, 16'($urandom),
                $urandom_range(1, 4), 1'b0);
    end
    junk_en = 1'b0;

    // Reset while a read is outstanding; a later mem_rd_done must be ignored
    stall = 1'b1;
    req_rd_en[0] = 1'b1; req_addr[0] = 15'h0005;
    tick(); tick(); tick();
    chk("midrst_in_read", 32'(mem_rd_en), 1);
    reset = 1'b0;
    clear_inputs();
    tick();
    check_zero();
    reset = 1'b1; last_ptr = 1'b1; stall = 1'b0;
    tick();
    mem_rd_done = 1'b1; mem_rd_data = 16'h7777;
    tick(); tick();
    chk("midrst_rd_en", 32'(mem_rd_en), 0);
    chk("midrst_no_done", 32'(req_done[0]), 0);

    // Memory never answers: timeout build completes with DEAD, otherwise READ persists
    run_round(1'b1, 2'b00, 15'h0123, 16'h0, 1'b0, 2'b00, 15'h0, 16'h0, 1, 1'b1);
`ifdef ARB_RD_TIMEOUT_EN
    chk("tmo_done_cycle", done_cyc, apply_cyc + 5);
`endif

    // Fixed priority: requester 0 holding reads starves requester 1 until it lets go
    fp_cnt[0] = 0; fp_cnt[1] = 0;
    fp_rd_en[0] = 1'b1; fp_rd_en[1] = 1'b1; fp_addr[0] = 15'h0100; fp_addr[1] = 15'h0200;
    repeat (30) tick();
    chk("fp_r0_served", 32'(fp_cnt[0] >= 5), 1);
    chk("fp_r1_starved", fp_cnt[1], 0);
    fp_rd_en[0] = 1'b0;
    repeat (10) tick();
    chk("fp_r1_served", 32'(fp_cnt[1] >= 1), 1);
    fp_rd_en[1] = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory data port (one read channel plus the write channel) between two requesters, e.g. the CPU data port and a DMA/loader engine.
- Sits between the requesters and memory_m.
- Arbitrates, latches the winning request, sequences the memory rd_en/rd_done handshake or a single-cycle write, and returns data plus a done pulse to the winner.

Parameters:
- ADDR_W, 15, word address width (matches memory_m).
- DATA_W, 16, data width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins ties.
- RD_TIMEOUT, 64, read timeout in cycles; used only with ARB_RD_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_rd_en[0:1]  in  1 each  read request, held until req_done.
- req_wr_en[0:1]  in  2 each  byte write enables; nonzero = write request, held until req_done.
- req_addr[0:1]  in  ADDR_W each  word address, stable while requesting.
- req_wr_data[0:1]  in  DATA_W each  write data.
- req_grant[0:1]  out  1 each  high while that requester owns the port.
- req_done[0:1]  out  1 each  one-cycle completion pulse.
- req_rd_data[0:1]  out  DATA_W each  read data; valid with req_done and held until that requester's next read completes.
- req_err[0:1]  out  1 each  timeout flag, pulses with req_done (macro only; tied 0 otherwise).
- mem_rd_en  out  1  to memory rd_en.
- mem_rd_addr  out  ADDR_W  to memory rd_addr.
- mem_rd_done  in  1  from memory rd_done.
- mem_rd_data  in  DATA_W  from memory rd_data.
- mem_wr_en  out  2  to memory wr_en.
- mem_wr_addr  out  ADDR_W  to memory wr_addr.
- mem_wr_data  out  DATA_W  to memory wr_data.

Behaviour:
- Clock/reset: single clock domain. reset is synchronous and active-low (reset==0 sampled at a rising edge).
- Reset values: all outputs 0, state IDLE, round-robin last-grant pointer = 1 (requester 0 wins the first tie).
- Reset mid-operation: the in-flight access is abandoned and no req_done is issued. mem_rd_en/mem_wr_en are 0 in the first cycle after the reset edge.
- All outputs are registered.
- Requester r is pending when req_rd_en[r]=1 or req_wr_en[r]!=0.
- If a requester asserts both read and write, the write is serviced first. The read stays pending and is serviced in a later grant.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE (cycle N): if any request is pending, pick the winner and latch its address, data and kind.
  - Winner selection: a sole pending requester always wins. On a tie with FIXED_PRIO=0, the requester not granted last wins. On a tie with FIXED_PRIO=1, requester 0 wins.
  - Transitions: write -> WRITE, read -> READ, nothing pending -> stay in IDLE.
- WRITE (cycle N+1), exactly one cycle:
  - mem_wr_en = latched byte enables; mem_wr_addr/mem_wr_data = latched values.
  - req_grant[g]=1, req_done[g]=1.
  - -> IDLE.
- READ (from cycle N+1):
  - mem_rd_en=1, mem_rd_addr = latched address, req_grant[g]=1.
  - Stays in READ until mem_rd_done is sampled 1; at that edge capture mem_rd_data -> RESP.
- RESP, one cycle:
  - mem_rd_en=0, req_done[g]=1, req_rd_data[g] = captured data, req_grant[g]=1.
  - -> IDLE.
- Latency:
  - Write: done in cycle N+1.
  - Read: done one cycle after the cycle in which mem_rd_done is sampled high.
  - At least one IDLE cycle separates consecutive grants, so a requester may drop or change its request on the edge where it samples req_done.
- The last-grant pointer updates on every grant.
- mem_rd_done outside READ is ignored.
- mem_wr_en is never asserted in the same cycle as mem_rd_en.
- Addresses are passed through unmodified; 0x7FFF is legal and there is no wrap logic.
- Requests that change before req_done are undefined usage. The latched copy is used regardless.

Optional Feature:
- ARB_RD_TIMEOUT_EN defined:
  - A counter clears on entry to READ and increments every cycle spent in READ.
  - If it reaches RD_TIMEOUT with mem_rd_done still 0, go to RESP with captured data 16'hDEAD and req_err[g]=1 alongside req_done[g].
- ARB_RD_TIMEOUT_EN undefined:
  - No counter; READ waits indefinitely.
  - req_err is constant 0.

Test Plan:
- Reset low for 2 cycles, then req_rd_en[0]=1, req_addr[0]=0x0010, memory returns 0xBEEF with 2-cycle latency -> mem_rd_en high from N+1, mem_rd_addr=0x0010; req_done[0] pulses once with req_rd_data[0]=0xBEEF.
- Both requesters read (0x0001, 0x0002) in the same cycle after reset, FIXED_PRIO=0 -> requester 0 served first, then requester 1; a repeated tie serves requester 0 again; each gets its own data, exactly one req_done each.
- req_wr_en[1]=2'b01, req_addr[1]=0x7FFF, req_wr_data[1]=0x1234 -> exactly one cycle with mem_wr_en=01, mem_wr_addr=0x7FFF, mem_wr_data=0x1234; req_done[1] in that same cycle; mem_rd_en stays 0.
- FIXED_PRIO=1, both requesters hold continuous reads -> requester 0 granted every time; requester 1 is served only after requester 0 deasserts.
- reset driven low while in READ before mem_rd_done -> next cycle all outputs 0, no req_done; a later mem_rd_done pulse is ignored.
- With ARB_RD_TIMEOUT_EN and RD_TIMEOUT=4, memory never asserts mem_rd_done -> req_done[0] and req_err[0] pulse after 4 READ cycles, req_rd_data[0]=0xDEAD; without the macro, READ persists and req_err stays 0.
